// File: rtl/snake_pkg.sv
// Shared types and constants for the tile plotter: FSM states, requester indices, coordinate widths.
// Also holds the arbitration helpers used by plot_arbiter (PLOT_ARB_RR_EN selects round-robin).
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int TILE_LOG2_DEF = 2;
  localparam int NREQ_DEF      = 3;

  localparam int REQ_CLEAR = 0;
  localparam int REQ_SNAKE = 1;
  localparam int REQ_FOOD  = 2;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  // Clear always wins; snake beats food.
  function automatic logic [NREQ_DEF-1:0] fixed_pick(input logic [NREQ_DEF-1:0] r);
    logic [NREQ_DEF-1:0] w;
    w = '0;
    if (r[REQ_CLEAR])      w[REQ_CLEAR] = 1'b1;
    else if (r[REQ_SNAKE]) w[REQ_SNAKE] = 1'b1;
    else if (r[REQ_FOOD])  w[REQ_FOOD]  = 1'b1;
    return w;
  endfunction

  // Clear always wins; a snake/food tie goes to whichever the pointer favours.
  function automatic logic [NREQ_DEF-1:0] rr_pick(input logic [NREQ_DEF-1:0] r,
                                                  input logic food_first);
    logic [NREQ_DEF-1:0] w;
    w = '0;
    if (r[REQ_CLEAR])                    w[REQ_CLEAR] = 1'b1;
    else if (r[REQ_SNAKE] && r[REQ_FOOD]) begin
      if (food_first) w[REQ_FOOD]  = 1'b1;
      else            w[REQ_SNAKE] = 1'b1;
    end
    else if (r[REQ_SNAKE])               w[REQ_SNAKE] = 1'b1;
    else if (r[REQ_FOOD])                w[REQ_FOOD]  = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/tile_scan_counter.sv
// Row-major pixel counter for one square tile; exposes the x/y offset of the current pixel
// and a flag on the last pixel of the tile.
module tile_scan_counter #(
  parameter int TILE_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic                 last,
  output logic [TILE_LOG2-1:0] off_x,
  output logic [TILE_LOG2-1:0] off_y
);

  logic [2*TILE_LOG2-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign last  = &cnt;
  assign off_x = cnt[TILE_LOG2-1:0];
  assign off_y = cnt[2*TILE_LOG2-1:TILE_LOG2];

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates tile-draw requests from clear/snake/food and streams each winning tile to the
// framebuffer write port. Define PLOT_ARB_RR_EN to alternate snake and food under contention.
//
// state   | meaning
// IDLE    | no burst; pick a winner when any req is high
// LOAD    | grant held; winner's origin and colour latched, pixel counter cleared
// DRAW    | one pixel plotted per cycle, 2**(2*TILE_LOG2) cycles
// DONE    | done pulse to the owner, grant released
module plot_arbiter
  import snake_pkg::*;
#(
  parameter int TILE_LOG2 = TILE_LOG2_DEF,
  parameter int NREQ      = NREQ_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*X_W-1:0]     req_x,
  input  logic [NREQ*Y_W-1:0]     req_y,
  input  logic [NREQ*COL_W-1:0]   req_colour,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [COL_W-1:0]        vga_colour,
  output logic                    vga_plot,
  output logic                    busy
);

  state_t            state;
  logic [NREQ-1:0]   win;
  logic [X_W-1:0]    sel_x, x_lat;
  logic [Y_W-1:0]    sel_y, y_lat;
  logic [COL_W-1:0]  sel_col, col_lat;
  logic              cnt_last;
  logic [TILE_LOG2-1:0] off_x, off_y;

`ifdef PLOT_ARB_RR_EN
  logic food_first;

  assign win = rr_pick(req, food_first);

  // Pointer flips away from whichever of snake/food just won.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) food_first <= 1'b0;
    else if (state == ST_IDLE) begin
      if (win[REQ_SNAKE])     food_first <= 1'b1;
      else if (win[REQ_FOOD]) food_first <= 1'b0;
    end
  end
`else
  assign win = fixed_pick(req);
`endif

  // The owner's slot, selected through the already-registered grant.
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_col = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_x   = req_x[i*X_W +: X_W];
        sel_y   = req_y[i*Y_W +: Y_W];
        sel_col = req_colour[i*COL_W +: COL_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      x_lat   <= '0;
      y_lat   <= '0;
      col_lat <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant <= win;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          x_lat   <= sel_x;
          y_lat   <= sel_y;
          col_lat <= sel_col;
          state   <= ST_DRAW;
        end
        ST_DRAW: begin
          if (cnt_last) begin
            done  <= grant;
            grant <= '0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tile_scan_counter #(.TILE_LOG2(TILE_LOG2)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_LOAD),
    .enable (state == ST_DRAW),
    .last   (cnt_last),
    .off_x  (off_x),
    .off_y  (off_y)
  );

  // Address wraps at port width; port is held at zero outside DRAW.
  assign vga_plot   = (state == ST_DRAW);
  assign vga_x      = vga_plot ? x_lat + X_W'(off_x) : '0;
  assign vga_y      = vga_plot ? y_lat + Y_W'(off_y) : '0;
  assign vga_colour = vga_plot ? col_lat : '0;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: table of single bursts plus hand-written corner sequences.
// Expectations follow PLOT_ARB_RR_EN when it is defined for the build.
module tb_plot_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  grant, done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy;

  int errors = 0;
  int n_checks = 0;

  logic [7:0] bx [3];
  logic [6:0] by [3];
  logic [2:0] bc [3];

  typedef struct {
    logic [2:0] r;
    int         win;
    logic [2:0] g;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } vec_t;

  vec_t vecs [8];
  logic [2:0] rr_exp [4];

  plot_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < 3; i++) begin
      req_x[i*8 +: 8]      = bx[i];
      req_y[i*7 +: 7]      = by[i];
      req_colour[i*3 +: 3] = bc[i];
    end
  endtask

  // Winner slot gets the vector's values; the others get clearly different ones.
  task automatic setup(input int win, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    for (int i = 0; i < 3; i++) begin
      bx[i] = (i == win) ? x : x ^ 8'h5A;
      by[i] = (i == win) ? y : y ^ 7'h2B;
      bc[i] = (i == win) ? c : ~c;
    end
    set_data();
  endtask

  // Starts in an IDLE cycle; ends in the IDLE cycle after DONE.
  task automatic burst(input logic [2:0] r, input int win, input logic [2:0] g,
                       input int mid_px, input logic [2:0] mid_r, input logic [2:0] end_r);
    logic [7:0] ex, px;
    logic [6:0] ey, py;
    logic [2:0] ec;
    ex = bx[win]; ey = by[win]; ec = bc[win];
    req = r;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("load_grant", {29'b0, grant}, {29'b0, g});
    chk("load_state", {30'b0, busy, vga_plot}, 32'd2);
    for (int p = 0; p < 16; p++) begin
      tick();
      px = ex + 8'(p % 4);
      py = ey + 7'(p / 4);
      chk($sformatf("pixel%0d", p), {13'b0, vga_plot, vga_x, vga_y, vga_colour},
          {13'b0, 1'b1, px, py, ec});
      if (p == mid_px) begin
        req = mid_r;
        req_x = '0;
        req_colour = {3{3'd1}};
      end
    end
    tick();
    chk("done_pulse", {26'b0, done, grant}, {26'b0, g, 3'b000});
    chk("done_port", {13'b0, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    req = end_r;
    tick();
    chk("after_done", {28'b0, done, busy}, 32'd0);
  endtask

  task automatic wait_grant(output logic [2:0] g);
    int n = 0;
    while (grant == 3'b000 && n < 40) begin tick(); n++; end
    chk("grant_seen", {31'b0, |grant}, 32'd1);
    g = grant;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done == 3'b000 && n < 40) begin tick(); n++; end
    chk("done_seen", {31'b0, |done}, 32'd1);
  endtask

  initial begin
    logic [2:0] g;
    vecs[0] = '{3'b001, 0, 3'b001, 8'd10,  7'd20,  3'd4};
    vecs[1] = '{3'b010, 1, 3'b010, 8'd159, 7'd119, 3'd5};
    vecs[2] = '{3'b100, 2, 3'b100, 8'd0,   7'd0,   3'd7};
    vecs[3] = '{3'b011, 0, 3'b001, 8'd254, 7'd126, 3'd3};
    vecs[4] = '{3'b101, 0, 3'b001, 8'd100, 7'd60,  3'd1};
    vecs[5] = '{3'b111, 0, 3'b001, 8'd159, 7'd119, 3'd6};
    vecs[6] = '{3'b010, 1, 3'b010, 8'd254, 7'd127, 3'd2};
    vecs[7] = '{3'b100, 2, 3'b100, 8'd255, 7'd0,   3'd0};
`ifdef PLOT_ARB_RR_EN
    rr_exp = '{3'b010, 3'b100, 3'b010, 3'b100};
`else
    rr_exp = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif

    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_outputs", {12'b0, grant, done, vga_x, vga_y, vga_colour},
        32'd0);
    chk("rst_flags", {30'b0, vga_plot, busy}, 32'd0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      setup(vecs[v].win, vecs[v].x, vecs[v].y, vecs[v].c);
      burst(vecs[v].r, vecs[v].win, vecs[v].g, -1, 3'b000, 3'b000);
    end

    // snake/food contention from a fresh pointer
    rst = 1'b0; tick(); rst = 1'b1; tick();
    setup(1, 8'd40, 7'd40, 3'd3);
    req = 3'b110;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      chk($sformatf("rr_order%0d", k), {29'b0, g}, {29'b0, rr_exp[k]});
      wait_done();
      chk($sformatf("rr_done%0d", k), {29'b0, done}, {29'b0, g});
      if (k == 3) req = 3'b000;
    end
    tick();

    // clear arrives mid-burst: snake finishes, clear goes next
    setup(1, 8'd70, 7'd30, 3'd5);
    burst(3'b010, 1, 3'b010, 5, 3'b011, 3'b011);
    bx[0] = 8'd12; by[0] = 7'd8; bc[0] = 3'd6;
    set_data();
    burst(3'b011, 0, 3'b001, -1, 3'b000, 3'b000);

    // colour change during DRAW is ignored
    setup(1, 8'd90, 7'd50, 3'd2);
    burst(3'b010, 1, 3'b010, 3, 3'b010, 3'b000);

    // reset at pixel 7 of a snake burst
    setup(1, 8'd20, 7'd10, 3'd4);
    req = 3'b010;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_pixel7", {16'b0, vga_plot, vga_x, vga_y}, {16'b0, 1'b1, 8'd23, 7'd11});
    rst = 1'b0;
    #1;
    chk("mid_rst_port", {12'b0, vga_plot, vga_x, vga_y, vga_colour, busy}, 32'd0);
    chk("mid_rst_grant", {26'b0, grant, done}, 32'd0);
    tick();
    chk("mid_rst_no_done", {29'b0, done}, 32'd0);
    rst = 1'b1;
    req = 3'b000;
    tick();
    setup(2, 8'd60, 7'd70, 3'd1);
    burst(3'b100, 2, 3'b100, -1, 3'b000, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
